// File: rtl/sprite_physics_fsm_pkg.sv
// Shared types and constants for the sprite motion/collision engine.
package sprite_phys_pkg;

  localparam int POS_W_DEF     = 11;
  localparam int FRAC_BITS_DEF = 6;
  localparam int FP_W_DEF      = POS_W_DEF + FRAC_BITS_DEF;
  localparam int SPD_W_DEF     = FRAC_BITS_DEF + POS_W_DEF - 1;

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_AIR    = 2'd1,
    ST_CLIMB  = 2'd2
  } motion_state_t;

  // HitEdgeCode bit map: [3]=left [2]=top [1]=right [0]=bottom
  localparam logic [3:0] EDGE_LEFT   = 4'b1000;
  localparam logic [3:0] EDGE_TOP    = 4'b0100;
  localparam logic [3:0] EDGE_RIGHT  = 4'b0010;
  localparam logic [3:0] EDGE_BOTTOM = 4'b0001;
  localparam logic [3:0] EDGE_EMBED  = 4'b1111;

  localparam logic [3:0] KEY_LEFT  = 4'd4;
  localparam logic [3:0] KEY_RIGHT = 4'd6;
  localparam logic [3:0] KEY_UP    = 4'd8;
  localparam logic [3:0] KEY_DOWN  = 4'd2;

  typedef struct packed {
    logic floor_hit;
    logic embedded;
    logic ceil_hit;
    logic left_hit;
    logic right_hit;
    logic rope_hit;
    logic jump_req;
  } frame_events_t;

endpackage

// File: rtl/sprite_physics_fsm_frame_event_latch.sv
// Sticky per-frame event flags; cleared on the commit strobe, which also opens the next frame.
module frame_event_latch
  import sprite_phys_pkg::*;
(
  input  logic          clk,
  input  logic          resetN,
  input  logic          startOfFrame,
  input  logic          wallCollision,
  input  logic          ladderCollision,
  input  logic          jumpIsPressed,
  input  logic [3:0]    HitEdgeCode,
  output frame_events_t events_o
);

  frame_events_t events_q;
  frame_events_t events_d;
  frame_events_t now_ev;

  always_comb begin
    now_ev           = '0;
    now_ev.floor_hit = wallCollision && (HitEdgeCode == EDGE_BOTTOM);
    now_ev.embedded  = wallCollision && (HitEdgeCode == EDGE_EMBED);
    now_ev.ceil_hit  = wallCollision && (HitEdgeCode == EDGE_TOP);
    now_ev.left_hit  = wallCollision && (HitEdgeCode == EDGE_LEFT);
    now_ev.right_hit = wallCollision && (HitEdgeCode == EDGE_RIGHT);
    now_ev.rope_hit  = ladderCollision;
    now_ev.jump_req  = jumpIsPressed;
  end

  // Strobe-cycle events seed the next frame instead of being merged into the one being committed.
  always_comb begin
    events_d = startOfFrame ? now_ev : (events_q | now_ev);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) events_q <= '0;
    else         events_q <= events_d;
  end

  assign events_o = events_q;

endmodule

// File: rtl/sprite_physics_fsm.sv
// Per-frame sprite physics: GROUND/AIR/CLIMB state, fixed-point velocity and position, screen clamping.
// Protocol: startOfFrame is a one-cycle strobe; the step it commits is visible on the outputs the next cycle.
module sprite_physics_fsm
  import sprite_phys_pkg::*;
#(
  parameter int POS_W       = POS_W_DEF,
  parameter int FRAC_BITS   = FRAC_BITS_DEF,
  parameter int INIT_X      = 280,
  parameter int INIT_Y      = 185,
  parameter int X_SPEED     = 40,
  parameter int JUMP_SPEED  = 500,
  parameter int GRAVITY     = 5,
  parameter int MAX_FALL    = 230,
  parameter int CLIMB_SPEED = 60,
  parameter int PUSHUP      = 8,
  parameter int CEIL_BOUNCE = 10,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 575,
  parameter int Y_MIN       = 0,
  parameter int Y_MAX       = 415
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame,
  input  logic                    freeze,
  input  logic                    jumpIsPressed,
  input  logic                    digitIsPressed,
  input  logic [3:0]              digit,
  input  logic                    wallCollision,
  input  logic                    ladderCollision,
  input  logic [3:0]              HitEdgeCode,
  output logic signed [POS_W-1:0] topLeftX,
  output logic signed [POS_W-1:0] topLeftY,
  output logic [1:0]              motionState,
  output logic                    facingLeft
);

  localparam int FP_W   = POS_W + FRAC_BITS;
  localparam int SPD_W  = FRAC_BITS + POS_W - 1;
  localparam int WIDE_W = FP_W + 2;
  localparam int VW     = SPD_W + 1;
  localparam int ONE_PX = 2 ** FRAC_BITS;

  localparam logic signed [FP_W-1:0]   INIT_X_FP = FP_W'(INIT_X * ONE_PX);
  localparam logic signed [FP_W-1:0]   INIT_Y_FP = FP_W'(INIT_Y * ONE_PX);
  localparam logic signed [FP_W-1:0]   X_MIN_FP  = FP_W'(X_MIN * ONE_PX);
  localparam logic signed [FP_W-1:0]   X_MAX_FP  = FP_W'(X_MAX * ONE_PX);
  localparam logic signed [FP_W-1:0]   Y_MIN_FP  = FP_W'(Y_MIN * ONE_PX);
  localparam logic signed [FP_W-1:0]   Y_MAX_FP  = FP_W'(Y_MAX * ONE_PX);
  localparam logic signed [WIDE_W-1:0] X_LO      = WIDE_W'(X_MIN);
  localparam logic signed [WIDE_W-1:0] X_HI      = WIDE_W'(X_MAX);
  localparam logic signed [WIDE_W-1:0] Y_LO      = WIDE_W'(Y_MIN);
  localparam logic signed [WIDE_W-1:0] Y_HI      = WIDE_W'(Y_MAX);

  localparam logic signed [SPD_W-1:0] VX_RIGHT  = SPD_W'(X_SPEED);
  localparam logic signed [SPD_W-1:0] VX_LEFT   = SPD_W'(-X_SPEED);
  localparam logic signed [SPD_W-1:0] VY_JUMP   = SPD_W'(-JUMP_SPEED);
  localparam logic signed [SPD_W-1:0] VY_UP     = SPD_W'(-CLIMB_SPEED);
  localparam logic signed [SPD_W-1:0] VY_DOWN   = SPD_W'(CLIMB_SPEED);
  localparam logic signed [SPD_W-1:0] VY_PUSH   = SPD_W'(-PUSHUP);
  localparam logic signed [SPD_W-1:0] VY_BOUNCE = SPD_W'(CEIL_BOUNCE);
  localparam logic signed [SPD_W-1:0] VY_MAXF   = SPD_W'(MAX_FALL);
  localparam logic signed [VW-1:0]    GRAV_W    = VW'(GRAVITY);
  localparam logic signed [VW-1:0]    MAXF_W    = VW'(MAX_FALL);

  frame_events_t ev;

  logic signed [FP_W-1:0]   pos_x_q, pos_x_d;
  logic signed [FP_W-1:0]   pos_y_q, pos_y_d;
  logic signed [SPD_W-1:0]  vx_q, vx_d;
  logic signed [SPD_W-1:0]  vy_q, vy_d;
  motion_state_t            state_q, state_d;
  logic                     facing_q, facing_d;

  logic                     key_left, key_right, key_up, key_down;
  logic signed [WIDE_W-1:0] sum_x, sum_y, pix_x, pix_y;
  logic signed [VW-1:0]     vy_grav;

  frame_event_latch u_events (
    .clk             (clk),
    .resetN          (resetN),
    .startOfFrame    (startOfFrame),
    .wallCollision   (wallCollision),
    .ladderCollision (ladderCollision),
    .jumpIsPressed   (jumpIsPressed),
    .HitEdgeCode     (HitEdgeCode),
    .events_o        (ev)
  );

  always_comb begin
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    vx_d      = vx_q;
    vy_d      = vy_q;
    state_d   = state_q;
    facing_d  = facing_q;
    key_left  = digitIsPressed && (digit == KEY_LEFT);
    key_right = digitIsPressed && (digit == KEY_RIGHT);
    key_up    = digitIsPressed && (digit == KEY_UP);
    key_down  = digitIsPressed && (digit == KEY_DOWN);
    // Position advances with the velocity from the previous commit, not the one computed this edge.
    sum_x     = WIDE_W'(pos_x_q) + WIDE_W'(vx_q);
    sum_y     = WIDE_W'(pos_y_q) + WIDE_W'(vy_q);
    pix_x     = sum_x >>> FRAC_BITS;
    pix_y     = sum_y >>> FRAC_BITS;
    vy_grav   = VW'(vy_q) + GRAV_W;

    if (startOfFrame && !freeze) begin
      if (ev.left_hit && ev.right_hit) vx_d = '0;
      else if (ev.left_hit)            vx_d = VX_RIGHT;
      else if (ev.right_hit)           vx_d = VX_LEFT;
      else if (key_left)               vx_d = VX_LEFT;
      else if (key_right)              vx_d = VX_RIGHT;
      else                             vx_d = '0;

      if (ev.rope_hit) begin
        state_d = ST_CLIMB;
        if (key_up)        vy_d = VY_UP;
        else if (key_down) vy_d = VY_DOWN;
        else               vy_d = '0;
      end else if (ev.embedded) begin
        state_d = ST_GROUND;
        vy_d    = VY_PUSH;
      end else if (ev.floor_hit) begin
        state_d = ev.jump_req ? ST_AIR : ST_GROUND;
        vy_d    = ev.jump_req ? VY_JUMP : '0;
      end else begin
        state_d = ST_AIR;
        if (ev.ceil_hit && (vy_q < 0)) vy_d = VY_BOUNCE;
        else if (vy_grav > MAXF_W)     vy_d = VY_MAXF;
        else                           vy_d = vy_grav[SPD_W-1:0];
      end

      pos_x_d = sum_x[FP_W-1:0];
      if (pix_x < X_LO) begin
        pos_x_d = X_MIN_FP;
        vx_d    = '0;
      end else if (pix_x > X_HI) begin
        pos_x_d = X_MAX_FP;
        vx_d    = '0;
      end

      pos_y_d = sum_y[FP_W-1:0];
      if (pix_y < Y_LO) begin
        pos_y_d = Y_MIN_FP;
        vy_d    = '0;
      end else if (pix_y > Y_HI) begin
        pos_y_d = Y_MAX_FP;
        vy_d    = '0;
      end

      if (key_left)       facing_d = 1'b1;
      else if (key_right) facing_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pos_x_q  <= INIT_X_FP;
      pos_y_q  <= INIT_Y_FP;
      vx_q     <= '0;
      vy_q     <= '0;
      state_q  <= ST_AIR;
      facing_q <= 1'b0;
    end else begin
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      state_q  <= state_d;
      facing_q <= facing_d;
    end
  end

  assign topLeftX    = pos_x_q[FP_W-1:FRAC_BITS];
  assign topLeftY    = pos_y_q[FP_W-1:FRAC_BITS];
  assign motionState = state_q;
  assign facingLeft  = facing_q;

endmodule

// File: tb/tb_sprite_physics_fsm.sv
// Bench for sprite_physics_fsm: directed frames plus random frames against an integer reference model.
module tb_sprite_physics_fsm;

  logic              clk = 1'b0;
  logic              resetN = 1'b0;
  logic              startOfFrame = 1'b0;
  logic              freeze = 1'b0;
  logic              jumpIsPressed = 1'b0;
  logic              digitIsPressed = 1'b0;
  logic [3:0]        digit = 4'd0;
  logic              wallCollision = 1'b0;
  logic              ladderCollision = 1'b0;
  logic [3:0]        HitEdgeCode = 4'd0;
  logic signed [10:0] topLeftX, topLeftY;
  logic [1:0]        motionState;
  logic              facingLeft;

  int n_total = 0;
  int n_bad   = 0;

  // expected {state[24:23], facing[22], x[21:11], y[10:0]}
  logic [24:0] exp_q[$];

  // reference model, fixed point in 1/64 px
  int m_x, m_y, m_vx, m_vy, m_state, m_face;
  bit f_floor, f_emb, f_ceil, f_left, f_right, f_rope, f_jump;

  sprite_physics_fsm dut (
    .clk             (clk),
    .resetN          (resetN),
    .startOfFrame    (startOfFrame),
    .freeze          (freeze),
    .jumpIsPressed   (jumpIsPressed),
    .digitIsPressed  (digitIsPressed),
    .digit           (digit),
    .wallCollision   (wallCollision),
    .ladderCollision (ladderCollision),
    .HitEdgeCode     (HitEdgeCode),
    .topLeftX        (topLeftX),
    .topLeftY        (topLeftY),
    .motionState     (motionState),
    .facingLeft      (facingLeft)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_x = 280 * 64; m_y = 185 * 64; m_vx = 0; m_vy = 0; m_state = 1; m_face = 0;
    {f_floor, f_emb, f_ceil, f_left, f_right, f_rope, f_jump} = '0;
  endtask

  task automatic model_push();
    exp_q.push_back({2'(m_state), 1'(m_face), 11'(m_x >>> 6), 11'(m_y >>> 6)});
  endtask

  task automatic model_commit(input bit dp, input logic [3:0] dg);
    int nvx, nvy, nst, nx, ny;
    bit kl, kr, ku, kd;
    kl = dp && dg == 4; kr = dp && dg == 6; ku = dp && dg == 8; kd = dp && dg == 2;
    nvx = (f_left && f_right) ? 0 : f_left ? 40 : f_right ? -40 : kl ? -40 : kr ? 40 : 0;
    if (f_rope) begin
      nst = 2; nvy = ku ? -60 : kd ? 60 : 0;
    end else if (f_emb) begin
      nst = 0; nvy = -8;
    end else if (f_floor) begin
      nst = f_jump ? 1 : 0; nvy = f_jump ? -500 : 0;
    end else begin
      nst = 1;
      nvy = (f_ceil && m_vy < 0) ? 10 : ((m_vy + 5 > 230) ? 230 : m_vy + 5);
    end
    nx = m_x + m_vx;
    ny = m_y + m_vy;
    if ((nx >>> 6) < 0)        begin nx = 0;        nvx = 0; end
    else if ((nx >>> 6) > 575) begin nx = 575 * 64; nvx = 0; end
    if ((ny >>> 6) < 0)        begin ny = 0;        nvy = 0; end
    else if ((ny >>> 6) > 415) begin ny = 415 * 64; nvy = 0; end
    if (kl) m_face = 1;
    else if (kr) m_face = 0;
    m_x = nx; m_y = ny; m_vx = nvx; m_vy = nvy; m_state = nst;
  endtask

  task automatic check_outputs();
    logic [24:0] e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check("state",  motionState, e[24:23]);
    check("facing", facingLeft,  e[22]);
    check("x",      topLeftX,    $signed(e[21:11]));
    check("y",      topLeftY,    $signed(e[10:0]));
  endtask

  task automatic cycle(input bit sof, input bit frz, input bit jmp, input bit dp, input logic [3:0] dg,
                       input bit wall, input bit lad, input logic [3:0] edg);
    startOfFrame = sof; freeze = frz; jumpIsPressed = jmp; digitIsPressed = dp; digit = dg;
    wallCollision = wall; ladderCollision = lad; HitEdgeCode = edg;
    @(posedge clk);
    if (sof) begin
      if (!frz) model_commit(dp, dg);
      model_push();
      {f_floor, f_emb, f_ceil, f_left, f_right, f_rope, f_jump} = '0;
    end
    f_floor |= wall && edg == 4'b0001;
    f_emb   |= wall && edg == 4'b1111;
    f_ceil  |= wall && edg == 4'b0100;
    f_left  |= wall && edg == 4'b1000;
    f_right |= wall && edg == 4'b0010;
    f_rope  |= lad;
    f_jump  |= jmp;
    #1;
    if (sof) check_outputs();
  endtask

  // idle cycles carry the events (edge alternates a/b), the strobe cycle carries only keys/freeze
  task automatic run_frame(input int len, input bit wall, input logic [3:0] edge_a, input logic [3:0] edge_b,
                           input bit lad, input bit jmp, input bit dp, input logic [3:0] dg, input bit frz);
    for (int i = 0; i < len - 1; i++)
      cycle(1'b0, 1'b0, jmp, dp, dg, wall, lad, (i % 2) ? edge_b : edge_a);
    cycle(1'b1, frz, 1'b0, dp, dg, 1'b0, 1'b0, 4'd0);
  endtask

  logic [3:0] edge_tab [7];
  logic [3:0] digit_tab[5];

  initial begin
    edge_tab  = '{4'b0001, 4'b1111, 4'b0100, 4'b1000, 4'b0010, 4'b0000, 4'b0101};
    digit_tab = '{4'd4, 4'd6, 4'd8, 4'd2, 4'd5};

    repeat (2) @(posedge clk);
    #1;
    model_reset();
    model_push();
    check_outputs();
    resetN = 1'b1;

    // free fall from reset: vy 5,10..50; y = 185 + floor(225/64)
    repeat (10) run_frame(3, 0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0);
    check("fall10_y", topLeftY, 188);
    check("fall10_state", motionState, 1);

    // standing on floor, walking right
    repeat (8) run_frame(3, 1, 4'b0001, 4'b0001, 0, 0, 1, 4'd6, 0);
    check("walk_state", motionState, 0);

    // jump, rise, hit ceiling, keep falling
    run_frame(3, 1, 4'b0001, 4'b0001, 0, 1, 0, 4'd0, 0);
    check("jump_state", motionState, 1);
    repeat (3) run_frame(3, 0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0);
    run_frame(3, 1, 4'b0100, 4'b0100, 0, 0, 0, 4'd0, 0);
    repeat (3) run_frame(3, 0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0);

    // rope with up key and jump together
    repeat (3) run_frame(3, 0, 4'd0, 4'd0, 1, 1, 1, 4'd8, 0);
    check("climb_state", motionState, 2);

    // wall pushes override keys; both walls cancel
    repeat (3) run_frame(3, 1, 4'b1000, 4'b1000, 0, 0, 1, 4'd4, 0);
    check("push_facing", facingLeft, 1);
    repeat (2) run_frame(3, 1, 4'b1000, 4'b0010, 0, 0, 1, 4'd4, 0);

    // frozen frames clear flags without moving
    repeat (2) run_frame(3, 1, 4'b0001, 4'b0001, 0, 1, 1, 4'd6, 1);
    run_frame(3, 0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0);
    check("after_freeze_state", motionState, 1);

    // long fall: vy saturates, y clamps at bottom
    repeat (200) run_frame(2, 0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0);
    check("clamp_y", topLeftY, 415);

    // reset mid-frame with a pending floor event
    cycle(0, 0, 0, 0, 4'd0, 1, 0, 4'b0001);
    cycle(0, 0, 0, 0, 4'd0, 1, 0, 4'b0001);
    #2;
    resetN = 1'b0;
    wallCollision = 1'b0; HitEdgeCode = 4'd0;
    #1;
    model_reset();
    model_push();
    check_outputs();
    @(posedge clk);
    #1;
    resetN = 1'b1;
    run_frame(3, 0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0);
    check("post_reset_state", motionState, 1);
    check("post_reset_y", topLeftY, 185);

    // random frames
    repeat (150) begin
      run_frame($urandom_range(2, 5), 1'($urandom_range(0, 1)), edge_tab[$urandom_range(0, 6)],
                edge_tab[$urandom_range(0, 6)], ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 1)), digit_tab[$urandom_range(0, 4)], ($urandom_range(0, 9) == 0));
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
